// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dmem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_FIELD_W = WORD_W - 2;

  typedef struct packed {
    logic [IDX_FIELD_W-1:0] index;
    logic [WORD_W-1:0]      data;
  } sb_entry_t;

  // Byte address to word index, aliased modulo the RAM size (words is a power of two).
  function automatic logic [IDX_FIELD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                         input int unsigned       words);
    return addr[WORD_W-1:2] & IDX_FIELD_W'(words - 1);
  endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// In-order circular store buffer with a youngest-match associative lookup port.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enq_i,
  input  sb_entry_t              enq_entry_i,
  input  logic                   deq_i,
  output sb_entry_t              head_entry_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   empty_o,
  output logic                   full_o,
  input  logic [IDX_FIELD_W-1:0] lookup_index_i,
  output logic                   hit_o,
  output logic [WORD_W-1:0]      hit_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t             mem_q [Depth];
  logic [PtrW-1:0]       head_q, tail_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  enq_ok, deq_ok;
  logic [PtrW-1:0]       pos;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CntW'(Depth));
  assign count_o      = count_q;
  assign head_entry_o = mem_q[head_q];
  assign enq_ok       = enq_i && !full_o;
  assign deq_ok       = deq_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) tail_q <= tail_q + PtrW'(1);
      if (deq_ok) head_q <= head_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; validity comes from head/count alone.
  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_q[tail_q] <= enq_entry_i;
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    pos        = '0;
    for (int k = 0; k < Depth; k++) begin
      pos = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (mem_q[pos].index == lookup_index_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[pos].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: buffers stores, drains them into a word RAM, forwards loads.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORDS  = 64,
  parameter int unsigned WORD_W = dmem_pkg::WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memWrite,
  input  logic                   memRead,
  input  logic [WORD_W-1:0]      memDataAddr,
  input  logic [WORD_W-1:0]      memWriteData,
  output logic [WORD_W-1:0]      memReadData,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   sb_empty
);

  localparam int unsigned IdxW = $clog2(WORDS);

  logic [WORD_W-1:0]      ram_q [WORDS];
  logic [IDX_FIELD_W-1:0] widx;
  logic [IdxW-1:0]        idx;
  sb_entry_t              enq_entry, head_entry;
  logic                   full, empty, drain, hit;
  logic [WORD_W-1:0]      hit_data;
  logic                   unused_bits;

  assign widx            = word_index(memDataAddr, WORDS);
  assign idx             = widx[IdxW-1:0];
  assign enq_entry.index = widx;
  assign enq_entry.data  = memWriteData;

  // A load holds off draining so the RAM port stays free, except when full.
  assign drain    = !empty && (!memRead || full);
  assign stall    = full;
  assign sb_empty = empty;

  sb_fifo #(
    .Depth(DEPTH)
  ) u_sb_fifo (
    .clk_i         (clk),
    .rst_ni        (reset),
    .enq_i         (memWrite),
    .enq_entry_i   (enq_entry),
    .deq_i         (drain),
    .head_entry_o  (head_entry),
    .count_o       (sb_count),
    .empty_o       (empty),
    .full_o        (full),
    .lookup_index_i(widx),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  always_ff @(posedge clk) begin
    if (reset && drain) ram_q[head_entry.index[IdxW-1:0]] <= head_entry.data;
  end

  assign memReadData = hit ? hit_data : ram_q[idx];

  assign unused_bits = ^{widx[IDX_FIELD_W-1:IdxW], head_entry.index[IDX_FIELD_W-1:IdxW]};

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWrite, memRead;
  logic [31:0] memDataAddr, memWriteData;
  logic [31:0] memReadData;
  logic        stall;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DEPTH (4),
    .WORDS (64),
    .WORD_W(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .memDataAddr (memDataAddr),
    .memWriteData(memWriteData),
    .memReadData (memReadData),
    .stall       (stall),
    .sb_count    (sb_count),
    .sb_empty    (sb_empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    memWrite     = w;
    memRead      = r;
    memDataAddr  = a;
    memWriteData = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    tick();
    tick();
    check_eq("rst_count", 32'(sb_count), 32'd0);
    check_eq("rst_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;

    // 1: forward then read back from RAM
    drive(1, 0, 32'h10, 32'hAA);
    tick();
    drive(0, 1, 32'h10, 32'h0);
    check_eq("t1_fwd", memReadData, 32'hAA);
    check_eq("t1_count", 32'(sb_count), 32'd1);
    tick();
    check_eq("t1_blocked", 32'(sb_count), 32'd1);
    drive(0, 0, 32'h10, 32'h0);
    tick();
    check_eq("t1_empty", 32'(sb_empty), 32'd1);
    drive(0, 1, 32'h10, 32'h0);
    check_eq("t1_ram", memReadData, 32'hAA);

    // 2: youngest entry wins
    drive(1, 0, 32'h20, 32'h1);
    tick();
    drive(1, 0, 32'h20, 32'h2);
    tick();
    drive(0, 1, 32'h20, 32'h0);
    check_eq("t2_young", memReadData, 32'h2);
    tick();
    check_eq("t2_young2", memReadData, 32'h2);
    drive(0, 0, 32'h0, 32'h0);
    tick();
    tick();
    check_eq("t2_empty", 32'(sb_empty), 32'd1);
    drive(0, 1, 32'h20, 32'h0);
    check_eq("t2_ram", memReadData, 32'h2);

    // 3: fill under continuous loads, single-cycle stall, held store
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    check_eq("t3_count4", 32'(sb_count), 32'd4);
    check_eq("t3_stall", 32'(stall), 32'd1);
    check_eq("t3_fwd_full", memReadData, 32'h103);
    drive(1, 1, 32'h10, 32'h104);
    tick();
    check_eq("t3_count3", 32'(sb_count), 32'd3);
    check_eq("t3_unstall", 32'(stall), 32'd0);
    drive(1, 0, 32'h10, 32'h104);
    tick();
    check_eq("t3_accept", 32'(sb_count), 32'd3);
    drive(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t3_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'(4 * i), 32'h0);
      check_eq($sformatf("t3_rd%0d", i), memReadData, 32'h100 + 32'(i));
    end

    // 4: pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h80 + 32'(4 * i), 32'h1000 + 32'(i));
      tick();
      if (i % 2 == 1) begin
        drive(0, 0, 32'h0, 32'h0);
        tick();
      end
    end
    drive(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t4_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 32'h80 + 32'(4 * i), 32'h0);
      check_eq($sformatf("t4_rd%0d", i), memReadData, 32'h1000 + 32'(i));
    end

    // 5: reset discards pending stores, RAM survives
    drive(1, 0, 32'h40, 32'h1111);
    tick();
    drive(0, 0, 32'h0, 32'h0);
    tick();
    check_eq("t5_pre_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h40 + 32'(4 * i), 32'hDEAD);
      tick();
    end
    check_eq("t5_count3", 32'(sb_count), 32'd3);
    reset = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    tick();
    check_eq("t5_count0", 32'(sb_count), 32'd0);
    check_eq("t5_stall", 32'(stall), 32'd0);
    check_eq("t5_empty", 32'(sb_empty), 32'd1);
    reset = 1'b1;
    drive(0, 1, 32'h40, 32'h0);
    check_eq("t5_ram", memReadData, 32'h1111);
    tick();

    // 6: aliasing and misalignment
    drive(1, 0, 32'h103, 32'h55);
    tick();
    drive(0, 1, 32'h000, 32'h0);
    check_eq("t6_fwd", memReadData, 32'h55);
    check_eq("t6_count", 32'(sb_count), 32'd1);
    drive(0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 1, 32'h000, 32'h0);
    check_eq("t6_empty", 32'(sb_empty), 32'd1);
    check_eq("t6_ram", memReadData, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
